// File: rtl/arbitro_memoria_dados_if.sv
// ----------------------------------------------------------------------------
// arbitro_memoria_dados_if
//
// Bundles every bus signal around the data-memory arbiter. Clock and reset
// are not part of the bundle and stay plain ports on the arbiter.
//
//   Port 0 (CPU load/store) and port 1 (I/O / loader), each with:
//     reqN    requester -> arbiter  request, held until ackN
//     weN     requester -> arbiter  1 = write, 0 = read
//     addrN   requester -> arbiter  word address
//     wdataN  requester -> arbiter  write data
//     ackN    arbiter -> requester  one-cycle completion pulse
//     rdataN  arbiter -> requester  read data, valid with ackN, then held
//   Memory side:
//     mem_data, mem_read_addr, mem_write_addr, mem_we  arbiter -> memory
//     mem_q                                            memory -> arbiter
//   Status:
//     busy    arbiter is not idle
//     owner   port currently or most recently granted
//
// Modports: slave = arbiter view, master = requester/memory environment view.
// ----------------------------------------------------------------------------
interface arbitro_memoria_dados_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
);
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  ack0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic [DATA_WIDTH-1:0] mem_data;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q;

    logic                  busy;
    logic                  owner;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_q,
        output ack0, rdata0, ack1, rdata1,
        output mem_data, mem_read_addr, mem_write_addr, mem_we,
        output busy, owner
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_q,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_data, mem_read_addr, mem_write_addr, mem_we,
        input  busy, owner
    );
endinterface

// File: rtl/arbitro_memoria_dados.sv
// ----------------------------------------------------------------------------
// arbitro_memoria_dados
//
// Two-requester round-robin arbiter and access sequencer for a single-clock
// data memory with a registered (1-cycle latency) read port. One access is
// in flight at a time; each access walks IDLE -> ACCESS -> CAPTURE -> ACK.
//
// Ports:
//   clock  system clock (the memory is clocked by the same net externally)
//   reset  synchronous, active-low reset
//   bus    arbitro_memoria_dados_if.slave: both requester handshakes, the
//          memory address/data/we/q set, and busy/owner status
// ----------------------------------------------------------------------------
module arbitro_memoria_dados #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    arbitro_memoria_dados_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;

    logic                  grant;
    logic                  grant_port;

    logic                  owner;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state is assigned with <= so every flop samples
        // the pre-edge values, independent of block ordering.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        next_state = state;
        grant      = 1'b0;
        grant_port = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    // Contention: the port that did not win last time goes.
                    grant      = 1'b1;
                    grant_port = ~owner;
                end else if (bus.req0) begin
                    grant      = 1'b1;
                    grant_port = 1'b0;
                end else if (bus.req1) begin
                    grant      = 1'b1;
                    grant_port = 1'b1;
                end
                if (grant) begin
                    next_state = ACCESS;
                end
            end
            ACCESS:  next_state = CAPTURE;
            CAPTURE: next_state = ACK;
            ACK:     next_state = IDLE;   // requests are ignored here
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Latched access, ownership, acks and read-data return
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            owner     <= 1'b1;            // port 0 wins the first contention
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            if (grant) begin
                owner     <= grant_port;
                lat_we    <= grant_port ? bus.we1    : bus.we0;
                lat_addr  <= grant_port ? bus.addr1  : bus.addr0;
                lat_wdata <= grant_port ? bus.wdata1 : bus.wdata0;
            end

            case (state)
                CAPTURE: begin
                    // mem_q now holds the word addressed during ACCESS.
                    if (!lat_we) begin
                        if (owner) begin
                            rdata1 <= bus.mem_q;
                        end else begin
                            rdata0 <= bus.mem_q;
                        end
                    end
                    if (owner) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                end
                ACK: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The write strobe also looks at reset directly so that asserting reset
    // during ACCESS blocks the write at that very edge, before the state
    // register has had a chance to leave ACCESS.
    assign bus.mem_we         = (state == ACCESS) & lat_we & reset;
    assign bus.mem_data       = lat_wdata;
    assign bus.mem_read_addr  = lat_addr;
    assign bus.mem_write_addr = lat_addr;

    assign bus.ack0   = ack0;
    assign bus.ack1   = ack1;
    assign bus.rdata0 = rdata0;
    assign bus.rdata1 = rdata1;
    assign bus.busy   = (state != IDLE);
    assign bus.owner  = owner;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// ----------------------------------------------------------------------------
// tb_arbitro_memoria_dados
//
// Directed bench for arbitro_memoria_dados. A behavioural registered-read
// memory sits on the memory side; both requester ports are driven from one
// linear initial block. Expected values are hand-derived constants.
// ----------------------------------------------------------------------------
module tb_arbitro_memoria_dados;

    localparam int DW = 32;
    localparam int AW = 15;

    logic clock;
    logic reset;

    int total = 0;
    int bad   = 0;

    // Read data each port should currently hold (rdata persists after ack).
    logic [DW-1:0] exp_rd0;
    logic [DW-1:0] exp_rd1;

    arbitro_memoria_dados_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    arbitro_memoria_dados #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-clock memory, registered read, 1-cycle latency.
    logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};

    always @(posedge clock) begin
        if (bus.mem_we) begin
            mem[bus.mem_write_addr] <= bus.mem_data;
        end
        bus.mem_q <= mem[bus.mem_read_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete access on a single port with the request held until ack.
    task automatic do_access(input logic port, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                             input string tag);
        if (port == 1'b0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
        if (!we) begin
            if (port == 1'b0) exp_rd0 = exp_rdata;
            else              exp_rd1 = exp_rdata;
        end

        tick();  // E0: grant, now in ACCESS
        check({tag, " access busy"},   {31'd0, bus.busy},   32'd1);
        check({tag, " access owner"},  {31'd0, bus.owner},  {31'd0, port});
        check({tag, " access we"},     {31'd0, bus.mem_we}, {31'd0, we});
        check({tag, " access waddr"},  {17'd0, bus.mem_write_addr}, {17'd0, addr});
        check({tag, " access raddr"},  {17'd0, bus.mem_read_addr},  {17'd0, addr});
        if (we) check({tag, " access data"}, bus.mem_data, wdata);

        tick();  // E1: CAPTURE
        check({tag, " capture we"},    {31'd0, bus.mem_we}, 32'd0);
        check({tag, " capture acks"},  {30'd0, bus.ack1, bus.ack0}, 32'd0);

        tick();  // E2: ACK
        check({tag, " ack0"},   {31'd0, bus.ack0}, {31'd0, ~port});
        check({tag, " ack1"},   {31'd0, bus.ack1}, {31'd0, port});
        check({tag, " ack we"}, {31'd0, bus.mem_we}, 32'd0);
        check({tag, " rdata0"}, bus.rdata0, exp_rd0);
        check({tag, " rdata1"}, bus.rdata1, exp_rd1);

        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();  // E3: back to IDLE
        check({tag, " done acks"}, {30'd0, bus.ack1, bus.ack0}, 32'd0);
        check({tag, " done busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        reset = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst busy",   {31'd0, bus.busy},   32'd0);
        check("rst owner",  {31'd0, bus.owner},  32'd1);
        check("rst acks",   {30'd0, bus.ack1, bus.ack0}, 32'd0);
        check("rst rdata0", bus.rdata0, 32'd0);
        check("rst rdata1", bus.rdata1, 32'd0);
        check("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst addr",   {17'd0, bus.mem_write_addr}, 32'd0);
        reset = 1'b1;
        tick();

        // ---- port 0 write, port 1 reads it back ----
        do_access(1'b0, 1'b1, 15'h0010, 32'hDEADBEEF, 32'h0, "p0 wr 0010");
        do_access(1'b1, 1'b0, 15'h0010, 32'h0,        32'hDEADBEEF, "p1 rd 0010");

        // ---- seed words for the contention test ----
        do_access(1'b0, 1'b1, 15'h0001, 32'h11111111, 32'h0, "p0 wr 0001");
        do_access(1'b1, 1'b1, 15'h0002, 32'h22222222, 32'h0, "p1 wr 0002");

        // ---- both ports requesting continuously: grants 0,1,0,1 ----
        // owner is 1 here, so port 0 goes first; acks land every 4 cycles.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 15'h0001;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 15'h0002;
        for (int c = 0; c < 16; c++) begin
            tick();
            check($sformatf("rr c%0d ack0", c), {31'd0, bus.ack0}, {31'd0, (c % 8) == 2});
            check($sformatf("rr c%0d ack1", c), {31'd0, bus.ack1}, {31'd0, (c % 8) == 6});
            check($sformatf("rr c%0d we", c),   {31'd0, bus.mem_we}, 32'd0);
            if (c % 8 == 0) check($sformatf("rr c%0d owner", c), {31'd0, bus.owner}, 32'd0);
            if (c % 8 == 4) check($sformatf("rr c%0d owner", c), {31'd0, bus.owner}, 32'd1);
            if (c % 8 == 2) check($sformatf("rr c%0d rdata0", c), bus.rdata0, 32'h11111111);
            if (c % 8 == 6) check($sformatf("rr c%0d rdata1", c), bus.rdata1, 32'h22222222);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        exp_rd0 = 32'h11111111;
        exp_rd1 = 32'h22222222;
        tick();
        check("rr idle busy", {31'd0, bus.busy}, 32'd0);

        // ---- boundary addresses ----
        do_access(1'b0, 1'b1, 15'h0000, 32'hA5A5A5A5, 32'h0, "p0 wr 0000");
        do_access(1'b1, 1'b1, 15'h7FFF, 32'h5A5A5A5A, 32'h0, "p1 wr 7fff");
        do_access(1'b0, 1'b0, 15'h7FFF, 32'h0, 32'h5A5A5A5A, "p0 rd 7fff");
        do_access(1'b1, 1'b0, 15'h0000, 32'h0, 32'hA5A5A5A5, "p1 rd 0000");

        // ---- reset during ACCESS of a write: write and ack are abandoned ----
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 15'h0020; bus.wdata0 = 32'hCAFEF00D;
        tick();
        check("mid rst access we", {31'd0, bus.mem_we}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid rst we gated", {31'd0, bus.mem_we}, 32'd0);
        bus.req0 = 1'b0;
        tick();
        check("mid rst busy",   {31'd0, bus.busy},  32'd0);
        check("mid rst ack0",   {31'd0, bus.ack0},  32'd0);
        check("mid rst owner",  {31'd0, bus.owner}, 32'd1);
        check("mid rst rdata0", bus.rdata0, 32'd0);
        reset = 1'b1;
        exp_rd0 = '0;
        exp_rd1 = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("post rst c%0d ack0", c), {31'd0, bus.ack0}, 32'd0);
        end
        do_access(1'b1, 1'b0, 15'h0020, 32'h0, 32'h0, "p1 rd 0020");

        // ---- req0 held through the ack cycle and one more ----
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 15'h0010;
        tick();
        tick();
        tick();
        check("hold ack0",   {31'd0, bus.ack0}, 32'd1);
        check("hold rdata0", bus.rdata0, 32'hDEADBEEF);
        tick();  // ACK edge: req0 still high but must be ignored
        check("hold no regrant busy", {31'd0, bus.busy}, 32'd0);
        check("hold no regrant ack0", {31'd0, bus.ack0}, 32'd0);
        tick();  // req0 still high in IDLE: a fresh access starts
        check("hold regrant busy",  {31'd0, bus.busy},  32'd1);
        check("hold regrant owner", {31'd0, bus.owner}, 32'd0);
        check("hold regrant raddr", {17'd0, bus.mem_read_addr}, 32'h0010);
        bus.req0 = 1'b0;  // dropped after grant: still completes
        tick();
        tick();
        check("late drop ack0",   {31'd0, bus.ack0}, 32'd1);
        check("late drop rdata0", bus.rdata0, 32'hDEADBEEF);
        tick();
        check("late drop end ack0", {31'd0, bus.ack0}, 32'd0);
        check("late drop end busy", {31'd0, bus.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria_dados.md
Name: arbitro_memoria_dados

Overview:
- Two-requester arbiter and access sequencer for the single-clock data memory (32-bit words, 15-bit word address, registered read with 1-cycle latency).
- Port 0 is the CPU load/store path. Port 1 is the I/O / loader path.
- Grants are round-robin and one access is in flight at a time.
- Each requester sees a simple req/ack handshake. The memory sees one clean address/data/we set per access.

Parameters:
DATA_WIDTH, 32, word width of data paths
ADDR_WIDTH, 15, word address width

Ports:
clock  in  1  single system clock; also drives both memory clocks externally
reset  in  1  synchronous, active-low reset
req0  in  1  port 0 request; held high until ack0 is seen
we0  in  1  port 0 direction: 1 = write, 0 = read; stable while req0 is high
addr0  in  ADDR_WIDTH  port 0 word address
wdata0  in  DATA_WIDTH  port 0 write data
ack0  out  1  one-cycle completion pulse for port 0
rdata0  out  DATA_WIDTH  port 0 read data; valid while ack0=1, then held
req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
mem_data  out  DATA_WIDTH  write data to memory
mem_read_addr  out  ADDR_WIDTH  memory read address
mem_write_addr  out  ADDR_WIDTH  memory write address
mem_we  out  1  memory write enable
mem_q  in  DATA_WIDTH  memory registered read data
busy  out  1  1 whenever state != IDLE
owner  out  1  index of the port currently or last granted

Behaviour:
- States: IDLE, ACCESS, CAPTURE, ACK. Encoding is free.
- Reset (reset=0 at a clock edge):
  - state <= IDLE, ack0/ack1 <= 0, rdata0/rdata1 <= 0.
  - Latched addr/data/we <= 0; owner <= 1, so port 0 wins the first contention.
  - Reset dominates every other event at that edge.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both req high: grant the port != owner (round-robin).
  - On grant: latch we/addr/wdata of the granted port, owner <= granted port, go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_read_addr = mem_write_addr = latched addr; mem_data = latched wdata.
  - mem_we = latched we AND reset. mem_we is combinational, so an active-low reset during ACCESS suppresses the write.
  - The memory performs the write, or captures the read, at the closing edge. Go to CAPTURE.
- CAPTURE: mem_we = 0 and mem_q is valid. At the closing edge:
  - Read: rdata[owner] <= mem_q.
  - Write: rdata unchanged.
  - ack[owner] <= 1; go to ACK.
- ACK:
  - ack[owner] is high for exactly this cycle; all requests are ignored.
  - At the closing edge: ack <= 0, go to IDLE.
  - The requester must drop or change req at that same edge.
- Latency and throughput:
  - Request sampled in IDLE at edge E0; ack visible in the cycle after E2.
  - 3 cycles from sampling to ack; one access per 4 cycles at most.
- Outside ACCESS: mem_we = 0, address/data outputs hold the latched values, no glitching writes.
- A req that drops before it is granted is simply not served. A req that drops after grant still completes and still acks.
- Reset mid-access (ACCESS, CAPTURE or ACK): no ack is issued and the access is abandoned. A write is lost only if reset is low during ACCESS.
- busy = (state != IDLE). owner changes only on a grant or on reset.
- Address and data are carried unmodified: no wrap or range check. The full ADDR_WIDTH range is valid.

Test Plan:
- After reset, port 0 writes 0xDEADBEEF to addr 0x0010 -> mem_we=1 for exactly 1 cycle with mem_write_addr=0x0010; ack0 pulses once, 3 cycles after sampling; ack1 stays 0.
- Port 1 reads addr 0x0010 -> rdata1=0xDEADBEEF during the ack1 cycle; mem_we stays 0 throughout.
- req0 and req1 high continuously (reads of 0x1 and 0x2) -> grants alternate 0,1,0,1; each ack spaced 4 cycles; rdata routed to the correct port.
- Boundary addresses 0x0000 and 0x7FFF written with distinct values, then read back -> exact values returned, no aliasing.
- reset=0 during ACCESS of a port 0 write to 0x0020 (old value 0x0) -> mem_we=0, no ack0, busy=0 after the edge; a later read of 0x0020 returns 0x0.
- Requester holds req0 high through the ack cycle for one extra cycle -> no second grant during ACK; a new access starts only if req0 is still high in IDLE.
